// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/decode front end: FSM states, MIPS field
// positions and PC arithmetic helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [31:0] PC_INC = 32'd4;

  // Instruction addresses are word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Splits a 32-bit MIPS instruction word into its decode fields; shared with
// later decode logic.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm
);

  // NOTE: pure continuous assigns; with no procedural block there is no path
  // by which a latch could be inferred.
  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/ID staging: owns the PC, drives a req/ack
// instruction-memory port and presents one buffered instruction to decode.
module fetch_decode_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,

  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,

  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,

  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  redirect_tgt;
  logic [31:0]  fetch_pc;

  assign redirect_tgt = align_pc(redirect_pc);
  // Address the next request should use: a redirect this cycle wins over pc.
  assign fetch_pc     = redirect_valid ? redirect_tgt : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the IF/ID buffer is ordinary flops, so it takes defined reset
    // values along with the control state.
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= PC_INC;
    end else begin
      // NOTE: non-blocking throughout so every decision below sees the
      // pre-edge register values, regardless of statement order.
      if (redirect_valid) begin
        pc       <= redirect_tgt;
        id_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
          state     <= FETCH;
        end

        FETCH: begin
          if (redirect_valid) begin
            // An issued request is never withdrawn: without an ack the old
            // one must still be drained before the new target goes out.
            if (imem_ack) imem_addr <= redirect_tgt;
            else          state     <= DRAIN;
          end else if (imem_ack) begin
            id_instr    <= imem_rdata;
            id_pc       <= imem_addr;
            id_pc_plus4 <= imem_addr + PC_INC;
            id_valid    <= 1'b1;
            pc          <= pc + PC_INC;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (redirect_valid || !id_stall) begin
            id_valid  <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= FETCH;
          end
        end

        DRAIN: begin
          if (imem_ack) begin
            imem_addr <= fetch_pc;
            state     <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  instr_field_split u_split (
    .instr  (id_instr),
    .opcode (id_opcode),
    .rs     (id_rs),
    .rt     (id_rt),
    .rd     (id_rd),
    .shamt  (id_shamt),
    .funct  (id_funct),
    .imm    (id_imm)
  );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: a memory/program-flow model pushes
// expected presentations, a monitor pops and compares them.
module tb_fetch_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm;

  always #5 clk = ~clk;

  fetch_decode_stage #(.RESET_PC(RST_PC)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_opcode      (id_opcode),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_shamt       (id_shamt),
    .id_funct       (id_funct),
    .id_imm         (id_imm)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_total   = 0;
  int   n_pass    = 0;
  int   n_present = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  // Program image: a fixed word at the reset vector, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h2008_FFFF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Program-flow model: the next address that should reach decode.
  logic [31:0] exp_pc;
  bit          stale;
  bit          outstanding;
  logic [31:0] out_addr;
  int          wait_left;
  int          fixed_wait;
  bit          random_mode;
  bit          want_stall;
  bit          want_redirect;
  logic [31:0] want_target;

  // One cycle: observe after the last edge, answer as memory, drive the
  // control inputs for the next edge and advance the model accordingly.
  task automatic step();
    bit          ack;
    bit          spur;
    logic [31:0] rdata;
    @(negedge clk);
    ack   = 1'b0;
    spur  = 1'b0;
    rdata = $urandom;
    if (outstanding) begin
      check("req_held", imem_req, 1);
      check("addr_stable", imem_addr, out_addr);
    end
    if (imem_req) begin
      if (!outstanding) begin
        outstanding = 1'b1;
        out_addr    = imem_addr;
        wait_left   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        if (!stale) check("req_addr", imem_addr, exp_pc);
      end
      if (wait_left == 0) begin
        ack   = 1'b1;
        rdata = mem_word(imem_addr);
      end else begin
        wait_left--;
      end
    end else if (random_mode) begin
      spur = ($urandom_range(0, 3) == 0);
    end

    imem_ack       = ack | spur;
    imem_rdata     = rdata;
    id_stall       = want_stall;
    redirect_valid = want_redirect;
    redirect_pc    = want_target;

    if (ack) outstanding = 1'b0;
    if (want_redirect) begin
      exp_pc = want_target & ~32'd3;
      stale  = imem_req && !ack;
    end else if (ack) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        sb_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
    end
    want_redirect = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_pc_plus4", id_pc_plus4, 4);
    check("rst_id_opcode", id_opcode, 0);
    check("rst_id_rs", id_rs, 0);
    check("rst_id_rt", id_rt, 0);
    check("rst_id_rd", id_rd, 0);
    check("rst_id_shamt", id_shamt, 0);
    check("rst_id_funct", id_funct, 0);
    check("rst_id_imm", id_imm, 0);
  endtask

  // Monitor: each new presentation pops one expectation; while it stays
  // presented (including stalls) every output is compared against it.
  bit   mon_prev = 1'b0;
  exp_t cur      = '{pc: 32'h0, instr: 32'h0};

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
    end else if (id_valid) begin
      if (!mon_prev) begin
        n_present++;
        check("sb_has_entry", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) cur = sb_q.pop_front();
      end
      check("id_pc", id_pc, cur.pc);
      check("id_instr", id_instr, cur.instr);
      check("id_pc_plus4", id_pc_plus4, cur.pc + 32'd4);
      check("id_opcode", id_opcode, cur.instr >> 26);
      check("id_rs", id_rs, (cur.instr >> 21) & 32'h1F);
      check("id_rt", id_rt, (cur.instr >> 16) & 32'h1F);
      check("id_rd", id_rd, (cur.instr >> 11) & 32'h1F);
      check("id_shamt", id_shamt, (cur.instr >> 6) & 32'h1F);
      check("id_funct", id_funct, cur.instr & 32'h3F);
      check("id_imm", id_imm, cur.instr & 32'hFFFF);
      mon_prev = 1'b1;
    end else begin
      mon_prev = 1'b0;
    end
  end

  initial begin
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_pc         = RST_PC;
    stale          = 1'b0;
    outstanding    = 1'b0;
    out_addr       = '0;
    wait_left      = 0;
    fixed_wait     = 0;
    random_mode    = 1'b0;
    want_stall     = 1'b0;
    want_redirect  = 1'b0;
    want_target    = '0;

    repeat (2) @(negedge clk);
    #1 check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // First request and zero-wait fetch of 0x2008_FFFF from the reset vector.
    step();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h40);
    want_stall = 1'b1;
    step();
    check("first_valid", id_valid, 1);
    check("first_pc", id_pc, 32'h40);
    check("first_pc_plus4", id_pc_plus4, 32'h44);
    check("first_opcode", id_opcode, 6'h08);
    check("first_rs", id_rs, 0);
    check("first_rt", id_rt, 8);
    check("first_imm", id_imm, 16'hFFFF);

    // Three stalled edges in HOLD, then release.
    for (int i = 0; i < 3; i++) begin
      if (i == 2) want_stall = 1'b0;
      step();
      check("stall_req_low", imem_req, 0);
      check("stall_valid", id_valid, 1);
      check("stall_pc", id_pc, 32'h40);
    end

    // Three wait cycles: request held on 0x44 for four cycles.
    fixed_wait = 3;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, 32'h44);
      check("wait_valid_low", id_valid, 0);
    end
    step();
    check("wait_valid_rise", id_valid, 1);
    check("wait_pc", id_pc, 32'h44);

    // Redirect to 0x1003 during a wait cycle of the 0x48 fetch.
    step();
    check("pre_redir_addr", imem_addr, 32'h48);
    want_redirect = 1'b1;
    want_target   = 32'h0000_1003;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      check("drain_req", imem_req, 1);
      check("drain_addr", imem_addr, 32'h48);
      check("drain_valid_low", id_valid, 0);
    end
    fixed_wait = 0;
    step();
    check("post_drain_addr", imem_addr, 32'h1000);
    check("post_drain_valid", id_valid, 0);
    step();
    check("redir_valid", id_valid, 1);
    check("redir_pc", id_pc, 32'h1000);

    // Redirect coinciding with ack.
    want_redirect = 1'b1;
    want_target   = 32'h0000_2000;
    step();
    check("ack_redir_addr_old", imem_addr, 32'h1004);
    step();
    check("ack_redir_valid", id_valid, 0);
    check("ack_redir_req", imem_req, 1);
    check("ack_redir_addr", imem_addr, 32'h2000);

    // Redirect while stalled in HOLD.
    want_stall    = 1'b1;
    want_redirect = 1'b1;
    want_target   = 32'h0000_3000;
    step();
    check("hold_valid", id_valid, 1);
    check("hold_pc", id_pc, 32'h2000);
    want_stall = 1'b0;
    step();
    check("stall_redir_valid", id_valid, 0);
    check("stall_redir_req", imem_req, 1);
    check("stall_redir_addr", imem_addr, 32'h3000);

    // PC wrap at the top of the address space.
    want_redirect = 1'b1;
    want_target   = 32'hFFFF_FFFC;
    step();
    step();
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_valid", id_valid, 1);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", id_pc_plus4, 32'h0);
    fixed_wait = 3;
    step();
    check("wrap_next_req", imem_req, 1);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Reset pulsed mid-FETCH, between clock edges.
    #2 rst_n = 1'b0;
    #1 check("async_req_drop", imem_req, 0);
    check_reset_state();
    imem_ack    = 1'b0;
    outstanding = 1'b0;
    stale       = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    exp_pc = RST_PC;

    // Randomized traffic: waits, stalls, redirects, spurious acks.
    random_mode = 1'b1;
    fixed_wait  = -1;
    for (int i = 0; i < 3000; i++) begin
      want_stall = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) begin
        want_redirect = 1'b1;
        want_target   = ($urandom_range(0, 3) == 0) ?
                        (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end
      step();
    end
    random_mode = 1'b0;
    want_stall  = 1'b0;
    repeat (10) step();
    check("presentations_seen", n_present > 100, 1);
    check("sb_backlog", sb_q.size() <= 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
